// File: rtl/over_screen_ctrl_pkg.sv
// Shared constants for the game-over screen: controller state encodings
// and the saturation limit of the mm:ss play timer.
package over_screen_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_OVER   = 2'd2,
        ST_UNUSED = 2'd3
    } ctrl_state_e;

    // 99:59 in BCD; the timer holds here instead of wrapping.
    localparam logic [15:0] TIME_MAX_BCD = 16'h9959;

endpackage

// File: rtl/bcd_time_counter.sv
// Four-digit BCD mm:ss counter with per-digit carry and saturation at 99:59.
module bcd_time_counter
    import over_screen_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] value_o
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // Next value: BCD ripple, seconds roll at 59, minutes at 99 (never reached past 99:59).
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = 16'h0000;
        end else if (inc && value_q != TIME_MAX_BCD) begin
            if (value_q[3:0] != 4'd9) begin
                value_d[3:0] = value_q[3:0] + 4'd1;
            end else begin
                value_d[3:0] = 4'd0;
                if (value_q[7:4] != 4'd5) begin
                    value_d[7:4] = value_q[7:4] + 4'd1;
                end else begin
                    value_d[7:4] = 4'd0;
                    if (value_q[11:8] != 4'd9) begin
                        value_d[11:8] = value_q[11:8] + 4'd1;
                    end else begin
                        value_d[11:8]  = 4'd0;
                        value_d[15:12] = value_q[15:12] + 4'd1;
                    end
                end
            end
        end
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (rst) value_q <= 16'h0000;
        else     value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/over_screen_ctrl.sv
// Game-over sequencer: runs the play timer, freezes it on solve, shows the
// over screen and turns a press+release on the return button into one pulse.
module over_screen_ctrl
    import over_screen_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start,
    input  logic        game_solved,
    input  logic        MOUSE_LEFT,
    input  logic        mouse_on_return_button,
    output logic        show_over,
    output logic [15:0] time_digits,
    output logic        return_to_menu,
    output logic [1:0]  ctrl_state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    ctrl_state_e   state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          armed_q, armed_d;
    logic          mouse_q;
    logic          ret_q, ret_d;
    logic          show_q;
    logic          clear, inc;
    logic          rise, fall;

    // Edges are taken against the previous-cycle button level; since that copy is
    // refreshed every cycle, a press begun before OVER never shows up as a rise.
    assign rise = MOUSE_LEFT & ~mouse_q;
    assign fall = ~MOUSE_LEFT & mouse_q;

    // Next state, tick divider, click detector and timer controls.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        armed_d = armed_q;
        ret_d   = 1'b0;
        clear   = 1'b0;
        inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (game_start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                    tick_d  = '0;
                end
            end
            ST_RUN: begin
                // Solve takes priority and swallows a coincident second tick.
                if (game_solved) begin
                    state_d = ST_OVER;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    inc    = 1'b1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_OVER: begin
                // Release location decides: on-button confirms if armed, off-button disarms.
                if (rise && mouse_on_return_button) begin
                    armed_d = 1'b1;
                end else if (fall) begin
                    if (armed_q && mouse_on_return_button) begin
                        ret_d   = 1'b1;
                        state_d = ST_IDLE;
                        armed_d = 1'b0;
                    end else if (!mouse_on_return_button) begin
                        armed_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            armed_q <= 1'b0;
            mouse_q <= 1'b0;
            ret_q   <= 1'b0;
            show_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            armed_q <= armed_d;
            mouse_q <= MOUSE_LEFT;
            ret_q   <= ret_d;
            show_q  <= (state_d == ST_OVER);
        end
    end

    bcd_time_counter u_time (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .inc     (inc),
        .value_o (time_digits)
    );

    assign show_over      = show_q;
    assign return_to_menu = ret_q;
    assign ctrl_state     = state_q;

endmodule

// File: tb/tb_over_screen_ctrl.sv
// Bench for over_screen_ctrl: an elapsed-seconds model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_over_screen_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_start, game_solved, MOUSE_LEFT, mouse_on_return_button;
    logic        show_over, return_to_menu;
    logic [15:0] time_digits;
    logic [1:0]  ctrl_state;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    over_screen_ctrl #(.TICK_DIV(TD)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .game_start             (game_start),
        .game_solved            (game_solved),
        .MOUSE_LEFT             (MOUSE_LEFT),
        .mouse_on_return_button (mouse_on_return_button),
        .show_over              (show_over),
        .time_digits            (time_digits),
        .return_to_menu         (return_to_menu),
        .ctrl_state             (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time is kept as plain elapsed seconds and converted to mm:ss on demand.
    int m_state = 0, m_secs = 0, m_cycles = 0;
    bit m_armed = 0, m_prev = 0, m_ret = 0;

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_secs = 0; m_cycles = 0;
            m_armed = 0; m_prev = 0; m_ret = 0;
        end else begin
            m_ret = 0;
            if (m_state == 0) begin
                if (game_start) begin m_state = 1; m_secs = 0; m_cycles = 0; end
            end else if (m_state == 1) begin
                if (game_solved) m_state = 2;
                else begin
                    m_cycles++;
                    if (m_cycles % TD == 0 && m_secs < 99 * 60 + 59) m_secs++;
                end
            end else begin
                if (MOUSE_LEFT && !m_prev && mouse_on_return_button) m_armed = 1;
                else if (!MOUSE_LEFT && m_prev) begin
                    if (m_armed && mouse_on_return_button) begin
                        m_ret = 1; m_state = 0; m_armed = 0;
                    end else if (!mouse_on_return_button) m_armed = 0;
                end
            end
            m_prev = MOUSE_LEFT;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_state", {14'd0, ctrl_state}, 16'(m_state));
            check("m_show",  {15'd0, show_over}, {15'd0, m_state == 2});
            check("m_ret",   {15'd0, return_to_menu}, {15'd0, m_ret});
            check("m_time",  time_digits, to_bcd(m_secs));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; game_start = 0; game_solved = 0; MOUSE_LEFT = 0; mouse_on_return_button = 0;
        cyc(2);
        check("rst_state", {14'd0, ctrl_state}, 16'd0);
        check("rst_show",  {15'd0, show_over}, 16'd0);
        check("rst_ret",   {15'd0, return_to_menu}, 16'd0);
        check("rst_time",  time_digits, 16'h0000);
        rst = 1'b0;
        chk_en = 1'b1;

        // Start and solve together in IDLE: start wins.
        game_start = 1; game_solved = 1; cyc(1); game_start = 0; game_solved = 0;
        check("start_wins", {14'd0, ctrl_state}, 16'd1);
        cyc(244);
        check("t_0101", time_digits, 16'h0101);
        check("t_0101_show", {15'd0, show_over}, 16'd0);
        cyc((5999 - 61) * TD);
        check("t_max", time_digits, 16'h9959);
        cyc(10 * TD);
        check("t_sat", time_digits, 16'h9959);

        game_solved = 1; cyc(1); game_solved = 0;
        check("over_state", {14'd0, ctrl_state}, 16'd2);
        check("over_show",  {15'd0, show_over}, 16'd1);

        // Press on the button, drag off, release off: no return.
        mouse_on_return_button = 1; MOUSE_LEFT = 1; cyc(1);
        mouse_on_return_button = 0; cyc(1);
        MOUSE_LEFT = 0; cyc(2);
        check("off_rel_ret",   {15'd0, return_to_menu}, 16'd0);
        check("off_rel_state", {14'd0, ctrl_state}, 16'd2);

        // Press and release on the button: one pulse, back to IDLE, time frozen.
        mouse_on_return_button = 1; MOUSE_LEFT = 1; cyc(2);
        MOUSE_LEFT = 0; cyc(1);
        check("on_rel_ret",   {15'd0, return_to_menu}, 16'd1);
        check("on_rel_state", {14'd0, ctrl_state}, 16'd0);
        check("on_rel_show",  {15'd0, show_over}, 16'd0);
        check("on_rel_time",  time_digits, 16'h9959);
        cyc(1);
        check("ret_one_cyc",  {15'd0, return_to_menu}, 16'd0);

        // Solve coincident with the 10th tick; button held since RUN.
        mouse_on_return_button = 0;
        game_start = 1; cyc(1); game_start = 0;
        cyc(29);
        MOUSE_LEFT = 1; mouse_on_return_button = 1;
        cyc(10);
        game_solved = 1; cyc(1); game_solved = 0;
        check("solve_time",  time_digits, 16'h0009);
        check("solve_state", {14'd0, ctrl_state}, 16'd2);
        check("solve_show",  {15'd0, show_over}, 16'd1);
        cyc(1); MOUSE_LEFT = 0; cyc(2);
        check("held_ret",   {15'd0, return_to_menu}, 16'd0);
        check("held_state", {14'd0, ctrl_state}, 16'd2);
        MOUSE_LEFT = 1; cyc(2); MOUSE_LEFT = 0; cyc(1);
        check("fresh_ret",  {15'd0, return_to_menu}, 16'd1);
        check("fresh_time", time_digits, 16'h0009);

        // Reset mid-game at 00:30.
        mouse_on_return_button = 0;
        cyc(1);
        game_start = 1; cyc(1); game_start = 0;
        cyc(120);
        check("t_0030", time_digits, 16'h0030);
        rst = 1; cyc(1);
        check("mid_rst_state", {14'd0, ctrl_state}, 16'd0);
        check("mid_rst_time",  time_digits, 16'h0000);
        check("mid_rst_show",  {15'd0, show_over}, 16'd0);
        check("mid_rst_ret",   {15'd0, return_to_menu}, 16'd0);
        rst = 0;
        game_start = 1; cyc(1); game_start = 0;
        check("restart_state", {14'd0, ctrl_state}, 16'd1);
        check("restart_time",  time_digits, 16'h0000);
        cyc(TD);
        check("restart_first", time_digits, 16'h0001);
        cyc(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
